parallel_mac_pe: RTL and testbench

//  Parametrised multi-lane successor of serial_pe: consumes LANES neuron/weight pairs per beat,

---
 rtl/parallel_mac_pe.sv | 163 ++++++++++++++++
 tb/tb_parallel_mac_pe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_mac_pe.sv
// parallel_mac_pe: multi-lane signed MAC processing element.
// Each accepted beat multiplies LANES neuron/weight pairs, sums the masked
// products through an adder tree and accumulates across a block framed by
// ctl[0] (first) and ctl[1] (last). Two pipeline stages, one beat per cycle.
// Optional feature macro PE_SAT_EN: saturating accumulator with sticky ovf
// flag; without it the accumulator wraps modulo 2^ACC_W and ovf is 0.
module parallel_mac_pe #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int ACC_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld_i,
  input  logic [1:0]              ctl,
  input  logic [LANES-1:0]        lane_en,
  input  logic [LANES*DATA_W-1:0] neuron,
  input  logic [LANES*DATA_W-1:0] weight,
  output logic [ACC_W-1:0]        result,
  output logic                    vld_o,
  output logic                    busy,
  output logic                    ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  // One guard bit above the wider of the accumulator and the beat sum, so
  // acc + sum never loses its true sign before being fitted back to ACC_W.
  localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam int NODES  = 2 * LANES - 1;

`ifdef PE_SAT_EN
  // True when v does not fit in a signed ACC_W value.
  function automatic logic clamps(input logic signed [EXT_W-1:0] v);
    return !((&v[EXT_W-1:ACC_W-1]) || !(|v[EXT_W-1:ACC_W-1]));
  endfunction

  // Saturate the widened sum to the signed ACC_W range.
  function automatic logic signed [ACC_W-1:0] fit_acc(input logic signed [EXT_W-1:0] v);
    if (clamps(v))
      return v[EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      return v[ACC_W-1:0];
  endfunction
`else
  // Modulo 2^ACC_W wrap of the widened sum.
  function automatic logic signed [ACC_W-1:0] fit_acc(input logic signed [EXT_W-1:0] v);
    return ACC_W'(v);
  endfunction
`endif

  logic signed [PROD_W-1:0] prod_p0 [LANES];
  logic signed [PROD_W-1:0] prod_p1 [LANES];
  logic                     vld_p1, first_p1, last_p1;
  logic signed [SUM_W-1:0]  node [NODES];
  logic signed [SUM_W-1:0]  sum_p1;
  logic signed [EXT_W-1:0]  wide_p1;
  logic signed [ACC_W-1:0]  acc_nx_p1;
  logic signed [ACC_W-1:0]  acc_p2;

  // ---- stage 0: per-lane signed products, disabled lanes forced to zero
  // Multiply each lane and apply the lane mask.
  always_comb begin
    logic signed [DATA_W-1:0] n_s;
    logic signed [DATA_W-1:0] w_s;
    logic signed [PROD_W-1:0] p;
    n_s = '0;
    w_s = '0;
    p   = '0;
    for (int l = 0; l < LANES; l++) begin
      n_s = neuron[l*DATA_W +: DATA_W];
      w_s = weight[l*DATA_W +: DATA_W];
      p   = PROD_W'(n_s) * PROD_W'(w_s);
      prod_p0[l] = lane_en[l] ? p : '0;
    end
  end

  // ---- stage 1: register products, framing and valid; track open block
  // Control side of the first stage, including the block-open flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      vld_p1 <= vld_i;
      if (vld_i) begin
        first_p1 <= ctl[0];
        last_p1  <= ctl[1];
        if (ctl[1])
          busy <= 1'b0;
        else if (ctl[0])
          busy <= 1'b1;
      end
    end
  end

  // Product registers only load on accepted beats; their valid guards use.
  always_ff @(posedge clk) begin
    if (vld_i)
      prod_p1 <= prod_p0;
  end

  // Heap-ordered adder tree: leaves at LANES-1.., root at node 0.
  always_comb begin
    for (int i = 0; i < NODES; i++)
      node[i] = '0;
    for (int l = 0; l < LANES; l++)
      node[LANES-1+l] = SUM_W'(prod_p1[l]);
    for (int i = LANES - 2; i >= 0; i--)
      node[i] = node[2*i+1] + node[2*i+2];
    sum_p1 = node[0];
  end

  // First beat reloads the accumulator, any other beat adds onto it.
  always_comb begin
    logic signed [EXT_W-1:0] base;
    base      = first_p1 ? '0 : EXT_W'(acc_p2);
    wide_p1   = base + EXT_W'(sum_p1);
    acc_nx_p1 = fit_acc(wide_p1);
  end

  // ---- stage 2: accumulate, publish block result with a one-cycle pulse
  // Accumulator, result hold register and output valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2 <= '0;
      result <= '0;
      vld_o  <= 1'b0;
    end else begin
      vld_o <= vld_p1 & last_p1;
      if (vld_p1) begin
        acc_p2 <= acc_nx_p1;
        if (last_p1)
          result <= acc_nx_p1;
      end
    end
  end

`ifdef PE_SAT_EN
  logic ovf_blk;
  logic ovf_nx_p1;

  // Sticky clamp flag for the open block, restarted by a first beat.
  always_comb ovf_nx_p1 = (first_p1 ? 1'b0 : ovf_blk) | clamps(wide_p1);

  // Block flag updates per beat; ovf output is published with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_blk <= 1'b0;
      ovf     <= 1'b0;
    end else if (vld_p1) begin
      ovf_blk <= ovf_nx_p1;
      if (last_p1)
        ovf <= ovf_nx_p1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_parallel_mac_pe.sv
// Testbench for parallel_mac_pe (DATA_W=16, LANES=4, ACC_W=32).
// Table of single-beat blocks, hand-written multi-cycle sequences and a
// randomized run checked against a block-level arithmetic model.
// Follows PE_SAT_EN the same way as the design.
module tb_parallel_mac_pe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld_i;
  logic [1:0]  ctl;
  logic [3:0]  lane_en;
  logic [63:0] neuron;
  logic [63:0] weight;
  logic [31:0] result;
  logic        vld_o;
  logic        busy;
  logic        ovf;

  parallel_mac_pe #(.DATA_W(16), .LANES(4), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .ctl(ctl), .lane_en(lane_en),
    .neuron(neuron), .weight(weight), .result(result), .vld_o(vld_o),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state (block level)
  longint      acc_m;
  bit          ovf_m, busy_m;
  bit          pend_v, pend_o, hold_o;
  logic [31:0] pend_r, hold_r;
  logic [31:0] obs_q[$];

  typedef struct {
    logic [3:0]  en;
    logic [63:0] n;
    logic [63:0] w;
    logic [31:0] exp_wrap;
    logic [31:0] exp_sat;
    logic        ovf_sat;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint beat_sum(input logic [3:0] e, input logic [63:0] n, input logic [63:0] w);
    longint s = 0;
    for (int l = 0; l < 4; l++)
      if (e[l])
        s += longint'($signed(n[l*16 +: 16])) * longint'($signed(w[l*16 +: 16]));
    return s;
  endfunction

  task automatic model_beat(input logic [1:0] c, input logic [3:0] e, input logic [63:0] n, input logic [63:0] w);
    longint t;
    bit     clamp;
    clamp = 1'b0;
    t = (c[0] ? 64'sd0 : acc_m) + beat_sum(e, n, w);
`ifdef PE_SAT_EN
    if (t > 64'sd2147483647) begin
      t = 64'sd2147483647;
      clamp = 1'b1;
    end else if (t < -64'sd2147483648) begin
      t = -64'sd2147483648;
      clamp = 1'b1;
    end
`else
    t = $signed(t[31:0]);
`endif
    acc_m = t;
    ovf_m = (c[0] ? 1'b0 : ovf_m) | clamp;
    if (c[1]) begin
      pend_v = 1'b1;
      pend_r = t[31:0];
      pend_o = ovf_m;
      busy_m = 1'b0;
    end else if (c[0]) begin
      busy_m = 1'b1;
    end
  endtask

  task automatic set_beat(input logic v, input logic [1:0] c, input logic [3:0] e, input logic [63:0] n, input logic [63:0] w);
    vld_i = v; ctl = c; lane_en = e; neuron = n; weight = w;
  endtask

  // One clock: model the beat presented at this edge, then compare outputs.
  task automatic tick();
    bit          take, ev, eo;
    logic [31:0] er;
    logic [1:0]  c;
    logic [3:0]  e;
    logic [63:0] n, w;
    take = rst_n && vld_i;
    c = ctl; e = lane_en; n = neuron; w = weight;
    ev = pend_v; er = pend_r; eo = pend_o;
    pend_v = 1'b0;
    @(posedge clk);
    #1;
    if (take) model_beat(c, e, n, w);
    if (ev) begin
      hold_r = er;
      hold_o = eo;
    end
    chk("vld_o", vld_o, ev);
    chk("result", result, hold_r);
    chk("busy", busy, busy_m);
    chk("ovf", ovf, hold_o);
    if (vld_o) obs_q.push_back(result);
  endtask

  // Asynchronous reset asserted mid-cycle, outputs must clear at once.
  task automatic do_reset();
    vld_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_result", result, 0);
    chk("rst_vld_o", vld_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    acc_m = 0; ovf_m = 0; busy_m = 0;
    pend_v = 0; hold_r = '0; hold_o = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  localparam logic [63:0] N_A = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] W_A = {16'd8, 16'd7, 16'd6, 16'd5};
  localparam logic [63:0] REP2 = {4{16'd2}};
  localparam logic [63:0] REP3 = {4{16'd3}};

  initial begin
    logic [31:0] ex;
    logic [15:0] ln, lw;
    logic [63:0] rn, rw;
    logic [1:0]  rc;
    bit          big;

    vt[0] = '{4'hF, N_A, W_A, 32'd70, 32'd70, 1'b0};
    vt[1] = '{4'b0001, {16'd5, 16'd5, 16'd5, 16'h8000}, {16'd5, 16'd5, 16'd5, 16'h7FFF},
              32'hC0008000, 32'hC0008000, 1'b0};
    vt[2] = '{4'hF, {4{16'h7FFF}}, {4{16'h7FFF}}, 32'hFFFC0004, 32'h7FFFFFFF, 1'b1};
    vt[3] = '{4'hF, {4{16'h8000}}, {4{16'h8000}}, 32'h00000000, 32'h7FFFFFFF, 1'b1};
    vt[4] = '{4'hF, {4{16'h8000}}, {4{16'h7FFF}}, 32'h00020000, 32'h80000000, 1'b1};
    vt[5] = '{4'h0, {4{16'h7FFF}}, {4{16'h7FFF}}, 32'd0, 32'd0, 1'b0};
    vt[6] = '{4'hF, {16'hFFFF, 16'hFFFE, 16'd3, 16'd4}, {16'd2, 16'd3, 16'hFFFB, 16'd6},
              32'd1, 32'd1, 1'b0};
    vt[7] = '{4'b1010, {16'd10, 16'd20, 16'd30, 16'd40}, {4{16'd1}}, 32'd40, 32'd40, 1'b0};

    rst_n = 1'b1;
    set_beat(1'b0, 2'b00, 4'h0, '0, '0);
    acc_m = 0; ovf_m = 0; busy_m = 0; pend_v = 0; pend_o = 0; pend_r = '0;
    hold_r = '0; hold_o = 0;
    #2;
    do_reset();

    // Single-beat blocks from the table
    for (int i = 0; i < 8; i++) begin
      set_beat(1'b1, 2'b11, vt[i].en, vt[i].n, vt[i].w);
      tick();
      vld_i = 1'b0;
      tick();
`ifdef PE_SAT_EN
      ex = vt[i].exp_sat;
      chk("tbl_ovf", ovf, vt[i].ovf_sat);
`else
      ex = vt[i].exp_wrap;
      chk("tbl_ovf", ovf, 0);
`endif
      chk("tbl_result", result, ex);
      chk("tbl_vld", vld_o, 1);
      tick();
      chk("tbl_pulse", vld_o, 0);
    end

    // 8-beat block with 0..3 idle cycles between beats
    for (int b = 0; b < 8; b++) begin
      set_beat(1'b1, {b == 7, b == 0}, 4'hF, REP2, REP3);
      tick();
      chk("blk_busy", busy, b != 7);
      vld_i = 1'b0;
      if (b < 7)
        for (int g = 0; g < b % 4; g++) tick();
    end
    tick();
    chk("blk_result", result, 192);
    chk("blk_vld", vld_o, 1);
    tick();

    // Block A (one beat) immediately followed by block B (8 beats)
    obs_q.delete();
    set_beat(1'b1, 2'b11, 4'hF, N_A, W_A);
    tick();
    for (int b = 0; b < 8; b++) begin
      set_beat(1'b1, {b == 7, b == 0}, 4'hF, REP2, REP3);
      tick();
    end
    vld_i = 1'b0;
    tick();
    tick();
    chk("b2b_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("b2b_first", obs_q[0], 70);
      chk("b2b_second", obs_q[1], 192);
    end

    // Reset in the middle of a block, then a fresh single-beat block
    for (int b = 0; b < 3; b++) begin
      set_beat(1'b1, {1'b0, b == 0}, 4'hF, REP2, REP3);
      tick();
    end
    chk("mid_busy", busy, 1);
    do_reset();
    set_beat(1'b1, 2'b11, 4'hF, N_A, W_A);
    tick();
    vld_i = 1'b0;
    tick();
    chk("post_rst_result", result, 70);
    chk("post_rst_vld", vld_o, 1);
    tick();

    // Restart while busy: the abandoned partial sum must not appear
    set_beat(1'b1, 2'b01, 4'hF, {4{16'h0100}}, {4{16'h0100}});
    tick();
    set_beat(1'b1, 2'b01, 4'hF, N_A, W_A);
    tick();
    set_beat(1'b1, 2'b10, 4'hF, REP2, REP3);
    tick();
    vld_i = 1'b0;
    tick();
    chk("restart_result", result, 94);
    tick();

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      big = ($urandom_range(0, 3) == 0);
      for (int l = 0; l < 4; l++) begin
        ln = big ? 16'($urandom) : 16'($urandom_range(0, 200) - 100);
        lw = big ? 16'($urandom) : 16'($urandom_range(0, 200) - 100);
        rn[l*16 +: 16] = ln;
        rw[l*16 +: 16] = lw;
      end
      rc[0] = ($urandom_range(0, 5) == 0);
      rc[1] = ($urandom_range(0, 5) == 0);
      set_beat($urandom_range(0, 3) != 0, rc, 4'($urandom), rn, rw);
      tick();
    end
    vld_i = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
